countdown_timer: RTL and testbench

//   Loadable HH:MM:SS countdown timer: the down-counting counterpart of the free-running clock.
//   A valid time is loaded, then decremented once per 1-second tick enable.
//   At 00:00:00 it stops and signals expiry.

---
 rtl/countdown_timer.sv | 167 ++++++++++++++++
 tb/tb_countdown_timer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// countdown_timer
//   Loadable HH:MM:SS countdown timer. A range-checked time is loaded and then
//   decremented once per 1-second tick while running. At 00:00:00 the timer
//   stops in EXPIRED and holds zero until it is cleared, reloaded or reset.
//
// Ports
//   clk            system clock, rising edge
//   reset          synchronous, active-high reset
//   tick           1-cycle enable from the shared 1 Hz prescaler
//   load           load strobe; load_hours/minutes/seconds hold the new time
//   start          start/resume strobe
//   pause          pause strobe
//   clear          abort strobe: count to zero, back to IDLE
//   hours/minutes/seconds   current count (registered)
//   running        high while in RUN
//   expired        high while in EXPIRED
//   expired_pulse  one cycle, on the cycle the count first shows zero
//   load_err       one cycle, when a load is rejected for range
//
// Control interface: every control input is a single-cycle strobe sampled on
// the rising edge; there is no handshake and no back-pressure. When several
// strobes are high together the one with the highest priority acts:
// reset > clear > load > pause > start > tick. A strobe that has no meaning
// in the current state is ignored (see the next-state logic for which
// strobes still consume the cycle).
module countdown_timer #(
    parameter int unsigned HOURS_MAX = 23
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       load,
    input  logic [4:0] load_hours,
    input  logic [5:0] load_minutes,
    input  logic [5:0] load_seconds,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       running,
    output logic       expired,
    output logic       expired_pulse,
    output logic       load_err
);

    localparam logic [4:0] HMAX = 5'(HOURS_MAX);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [4:0] hours_d;
    logic [5:0] minutes_d;
    logic [5:0] seconds_d;
    logic       expired_pulse_d;
    logic       load_err_d;

    logic       count_zero;
    logic       load_ok;
    logic [4:0] dec_hours;
    logic [5:0] dec_minutes;
    logic [5:0] dec_seconds;
    logic       dec_to_zero;

    assign count_zero = (hours == 5'd0) && (minutes == 6'd0) && (seconds == 6'd0);

    assign load_ok = (load_seconds <= 6'd59) && (load_minutes <= 6'd59) &&
                     (load_hours <= HMAX);

    // One-second decrement with borrow. Only used in RUN, where the count is
    // never zero, so the hours borrow cannot underflow.
    always_comb begin
        dec_hours   = hours;
        dec_minutes = minutes;
        dec_seconds = seconds;
        if (seconds != 6'd0) begin
            dec_seconds = seconds - 6'd1;
        end else begin
            dec_seconds = 6'd59;
            if (minutes != 6'd0) begin
                dec_minutes = minutes - 6'd1;
            end else begin
                dec_minutes = 6'd59;
                dec_hours   = hours - 5'd1;
            end
        end
    end

    // The decrement lands on zero exactly when the count is 00:00:01.
    assign dec_to_zero = (hours == 5'd0) && (minutes == 6'd0) && (seconds == 6'd1);

    // Next-state logic. clear, a load outside RUN (valid or not) and pause
    // each consume the cycle, so a lower-priority strobe in the same cycle
    // has no effect. A load during RUN is ignored entirely and lets the
    // lower-priority strobes act as if it were absent.
    always_comb begin
        state_d         = state_q;
        hours_d         = hours;
        minutes_d       = minutes;
        seconds_d       = seconds;
        expired_pulse_d = 1'b0;
        load_err_d      = 1'b0;

        if (clear) begin
            state_d   = ST_IDLE;
            hours_d   = 5'd0;
            minutes_d = 6'd0;
            seconds_d = 6'd0;
        end else if (load && (state_q != ST_RUN)) begin
            if (load_ok) begin
                state_d   = ST_IDLE;
                hours_d   = load_hours;
                minutes_d = load_minutes;
                seconds_d = load_seconds;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (pause) begin
            if (state_q == ST_RUN) begin
                state_d = ST_PAUSED;
            end
        end else if (start && ((state_q == ST_IDLE) || (state_q == ST_PAUSED)) &&
                     !count_zero) begin
            state_d = ST_RUN;
        end else if (tick && (state_q == ST_RUN)) begin
            hours_d   = dec_hours;
            minutes_d = dec_minutes;
            seconds_d = dec_seconds;
            if (dec_to_zero) begin
                state_d         = ST_EXPIRED;
                expired_pulse_d = 1'b1;
            end
        end
    end

    // Status flags are registered from the next state so they change on the
    // same edge as the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            hours         <= 5'd0;
            minutes       <= 6'd0;
            seconds       <= 6'd0;
            running       <= 1'b0;
            expired       <= 1'b0;
            expired_pulse <= 1'b0;
            load_err      <= 1'b0;
        end else begin
            state_q       <= state_d;
            hours         <= hours_d;
            minutes       <= minutes_d;
            seconds       <= seconds_d;
            running       <= (state_d == ST_RUN);
            expired       <= (state_d == ST_EXPIRED);
            expired_pulse <= expired_pulse_d;
            load_err      <= load_err_d;
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer
//   Directed vector table, hand-written expiry sequence and a randomized run
//   compared against a seconds-count reference model.
module tb_countdown_timer;

    localparam int unsigned HMAX = 23;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       load = 1'b0;
    logic [4:0] load_hours = '0;
    logic [5:0] load_minutes = '0;
    logic [5:0] load_seconds = '0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       clear = 1'b0;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       running;
    logic       expired;
    logic       expired_pulse;
    logic       load_err;

    countdown_timer #(.HOURS_MAX(HMAX)) dut (
        .clk           (clk),
        .reset         (reset),
        .tick          (tick),
        .load          (load),
        .load_hours    (load_hours),
        .load_minutes  (load_minutes),
        .load_seconds  (load_seconds),
        .start         (start),
        .pause         (pause),
        .clear         (clear),
        .hours         (hours),
        .minutes       (minutes),
        .seconds       (seconds),
        .running       (running),
        .expired       (expired),
        .expired_pulse (expired_pulse),
        .load_err      (load_err)
    );

    // Observed outputs packed as {hh, mm, ss, running, expired, pulse, err}.
    localparam int W = 21;
    logic [W-1:0] act;
    assign act = {hours, minutes, seconds, running, expired, expired_pulse, load_err};

    typedef struct {
        logic       rst;
        logic       tck;
        logic       ld;
        logic [4:0] lh;
        logic [5:0] lm;
        logic [5:0] ls;
        logic       st;
        logic       ps;
        logic       clr;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[$];

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_total = 0;
    int n_pass  = 0;
    int pulse_seen = 0;

    function automatic logic [W-1:0] pk(input int h, input int m, input int s,
                                        input bit r, input bit e, input bit p,
                                        input bit err);
        return {5'(h), 6'(m), 6'(s), r, e, p, err};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, want);
    endtask

    // ---------------- drivers ----------------
    task automatic idle_inputs();
        reset = 1'b0; tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0;
        load_hours = '0; load_minutes = '0; load_seconds = '0;
    endtask

    task automatic drive_cycle(input vec_t v);
        reset = v.rst; tick = v.tck; load = v.ld;
        load_hours = v.lh; load_minutes = v.lm; load_seconds = v.ls;
        start = v.st; pause = v.ps; clear = v.clr;
        @(posedge clk);
        #1;
        if (expired_pulse) pulse_seen++;
        idle_inputs();
    endtask

    task automatic step(input vec_t v, input string name);
        exp_q.push_back(v.exp);
        drive_cycle(v);
        check(name, 32'(act), 32'(exp_q.pop_front()));
    endtask

    function automatic vec_t mkv(input bit rst, input bit tck, input bit ld,
                                 input int lh, input int lm, input int ls,
                                 input bit st, input bit ps, input bit clr);
        vec_t v;
        v.rst = rst; v.tck = tck; v.ld = ld;
        v.lh = 5'(lh); v.lm = 6'(lm); v.ls = 6'(ls);
        v.st = st; v.ps = ps; v.clr = clr;
        v.exp = '0;
        return v;
    endfunction

    task automatic row(input vec_t v, input logic [W-1:0] e);
        vec_t r;
        r = v;
        r.exp = e;
        vecs.push_back(r);
    endtask

    task automatic idle_cycles(input int n);
        vec_t v;
        v = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) drive_cycle(v);
    endtask

    // ---------------- reference model ----------------
    // Count held as total seconds; states 0 idle, 1 run, 2 paused, 3 expired.
    int m_total = 0;
    int m_st    = 0;
    bit m_pulse = 0;
    bit m_err   = 0;

    function automatic void model_apply(input vec_t v);
        m_pulse = 0;
        m_err   = 0;
        if (v.rst) begin
            m_total = 0; m_st = 0;
        end else if (v.clr) begin
            m_total = 0; m_st = 0;
        end else if (v.ld && m_st != 1) begin
            if (int'(v.ls) <= 59 && int'(v.lm) <= 59 && int'(v.lh) <= int'(HMAX)) begin
                m_total = int'(v.lh) * 3600 + int'(v.lm) * 60 + int'(v.ls);
                m_st = 0;
            end else begin
                m_err = 1;
            end
        end else if (v.ps) begin
            if (m_st == 1) m_st = 2;
        end else if (v.st && (m_st == 0 || m_st == 2) && m_total != 0) begin
            m_st = 1;
        end else if (v.tck && m_st == 1) begin
            m_total = m_total - 1;
            if (m_total == 0) begin
                m_st = 3;
                m_pulse = 1;
            end
        end
    endfunction

    function automatic logic [W-1:0] model_out();
        return pk(m_total / 3600, (m_total / 60) % 60, m_total % 60,
                  m_st == 1, m_st == 3, m_pulse, m_err);
    endfunction

    // ---------------- test ----------------
    initial begin
        vec_t v;
        int pulses_before;

        // Vector table: (rst,tck,ld,lh,lm,ls,st,ps,clr) -> expected outputs.
        row(mkv(1,0,0, 0, 0, 0,0,0,0), pk( 0, 0, 0,0,0,0,0)); // reset state
        row(mkv(0,0,1, 1, 0, 0,0,0,0), pk( 1, 0, 0,0,0,0,0)); // load 01:00:00
        row(mkv(0,0,0, 0, 0, 0,1,0,0), pk( 1, 0, 0,1,0,0,0)); // start
        row(mkv(0,1,0, 0, 0, 0,0,0,0), pk( 0,59,59,1,0,0,0)); // borrow through hours
        row(mkv(0,0,1, 0, 0, 5,0,0,0), pk( 0,59,59,1,0,0,0)); // load in RUN ignored
        row(mkv(0,1,0, 0, 0, 0,0,1,0), pk( 0,59,59,0,0,0,0)); // pause+tick: tick dropped
        row(mkv(0,1,0, 0, 0, 0,0,0,0), pk( 0,59,59,0,0,0,0)); // tick while paused
        row(mkv(0,0,1, 0,60, 0,0,0,0), pk( 0,59,59,0,0,0,1)); // minutes 60 rejected
        row(mkv(0,0,1,HMAX+1,0,0,0,0,0), pk(0,59,59,0,0,0,1)); // hours too big
        row(mkv(0,0,1, 0, 1, 0,0,0,0), pk( 0, 1, 0,0,0,0,0)); // load 00:01:00
        row(mkv(0,0,0, 0, 0, 0,1,0,0), pk( 0, 1, 0,1,0,0,0)); // start
        row(mkv(0,0,0, 0, 0, 0,1,1,0), pk( 0, 1, 0,0,0,0,0)); // pause beats start
        row(mkv(0,0,0, 0, 0, 0,1,0,0), pk( 0, 1, 0,1,0,0,0)); // resume
        row(mkv(0,1,0, 0, 0, 0,0,0,0), pk( 0, 0,59,1,0,0,0)); // borrow from minutes
        row(mkv(0,0,0, 0, 0, 0,0,0,1), pk( 0, 0, 0,0,0,0,0)); // clear
        row(mkv(0,0,0, 0, 0, 0,1,0,0), pk( 0, 0, 0,0,0,0,0)); // start at zero ignored
        row(mkv(0,0,1, 0, 0, 1,0,0,0), pk( 0, 0, 1,0,0,0,0)); // load 00:00:01
        row(mkv(0,0,0, 0, 0, 0,1,0,0), pk( 0, 0, 1,1,0,0,0)); // start
        row(mkv(0,1,0, 0, 0, 0,0,0,0), pk( 0, 0, 0,0,1,1,0)); // expire with pulse
        row(mkv(0,1,0, 0, 0, 0,0,0,0), pk( 0, 0, 0,0,1,0,0)); // holds, no wrap
        row(mkv(0,0,0, 0, 0, 0,1,0,0), pk( 0, 0, 0,0,1,0,0)); // start in EXPIRED ignored
        row(mkv(0,0,1, 0, 0, 5,0,0,0), pk( 0, 0, 5,0,0,0,0)); // load leaves EXPIRED
        row(mkv(0,0,1, 2,10, 7,0,0,0), pk( 2,10, 7,0,0,0,0)); // load 02:10:07
        row(mkv(0,0,0, 0, 0, 0,1,0,0), pk( 2,10, 7,1,0,0,0)); // start
        row(mkv(0,0,1, 0, 0, 5,0,0,1), pk( 0, 0, 0,0,0,0,0)); // clear beats load
        row(mkv(0,0,1, 2,10, 7,0,0,0), pk( 2,10, 7,0,0,0,0)); // reload
        row(mkv(0,0,0, 0, 0, 0,1,0,0), pk( 2,10, 7,1,0,0,0)); // start
        row(mkv(0,1,0, 0, 0, 0,0,0,0), pk( 2,10, 6,1,0,0,0)); // tick
        row(mkv(1,1,0, 0, 0, 0,0,0,0), pk( 0, 0, 0,0,0,0,0)); // reset mid-RUN
        row(mkv(0,0,1,HMAX,59,59,0,0,0), pk(HMAX,59,59,0,0,0,0)); // largest legal load
        row(mkv(0,0,1, 0, 0,60,0,0,0), pk(HMAX,59,59,0,0,0,1)); // seconds 60 rejected
        row(mkv(0,0,0, 0, 0, 0,1,0,0), pk(HMAX,59,59,1,0,0,0)); // start

        idle_inputs();
        repeat (2) @(posedge clk);
        foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

        // Hand sequence: 00:00:03 with ticks spaced 10 clocks apart.
        v = mkv(1,0,0,0,0,0,0,0,0); drive_cycle(v);
        v = mkv(0,0,1,0,0,3,0,0,0); drive_cycle(v);
        v = mkv(0,0,0,0,0,0,1,0,0); drive_cycle(v);
        check("seq_running", 32'(running), 32'd1);
        pulses_before = pulse_seen;
        for (int k = 0; k < 3; k++) begin
            idle_cycles(9);
            v = mkv(0,1,0,0,0,0,0,0,0);
            drive_cycle(v);
            check($sformatf("seq_sec%0d", k), 32'(seconds), 32'(2 - k));
            if (k == 2) check("seq_pulse_at_zero", 32'(expired_pulse), 32'd1);
        end
        idle_cycles(6);
        check("seq_pulse_count", 32'(pulse_seen - pulses_before), 32'd1);
        check("seq_expired_hold", 32'(expired), 32'd1);
        check("seq_hold_zero", 32'(act), 32'(pk(0,0,0,0,1,0,0)));

        // Randomized run against the reference model.
        v = mkv(1,0,0,0,0,0,0,0,0);
        model_apply(v);
        v.exp = model_out();
        step(v, "rand_reset");
        for (int i = 0; i < 3000; i++) begin
            v.rst = ($urandom_range(0, 299) == 0);
            v.tck = ($urandom_range(0, 2) == 0);
            v.ld  = ($urandom_range(0, 14) == 0);
            v.lh  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'd0;
            v.lm  = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63))
                                                 : 6'($urandom_range(0, 1));
            v.ls  = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63))
                                                 : 6'($urandom_range(0, 8));
            v.st  = ($urandom_range(0, 5) == 0);
            v.ps  = ($urandom_range(0, 14) == 0);
            v.clr = ($urandom_range(0, 59) == 0);
            model_apply(v);
            v.exp = model_out();
            step(v, $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
